// File: rtl/td4_core.sv
// TD4 4-bit CPU execution core.
// Fetches from an external async ROM at adr=PC and executes one op per enabled clock.
module td4_core #(
  parameter logic [3:0] RESET_PC  = 4'h0,
  parameter logic [3:0] OUT_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [3:0] adr,
  input  logic [7:0] inst,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry
);

  logic [3:0] a, b, pc, outp;
  logic       c;

  logic [3:0] a_n, b_n, pc_n, out_n;
  logic       c_n;

  logic [3:0] op, im;
  logic [4:0] sum_a, sum_b;

  assign op    = inst[7:4];
  assign im    = inst[3:0];
  assign sum_a = {1'b0, a} + {1'b0, im};
  assign sum_b = {1'b0, b} + {1'b0, im};

  logic add_a, add_b, mov_ai, mov_bi, mov_ab;
  logic mov_ba, in_a, in_b, out_b, out_i;
  logic jmp, jnc;

  assign add_a  = (op == 4'b0000);
  assign add_b  = (op == 4'b0101);
  assign mov_ai = (op == 4'b0011);
  assign mov_bi = (op == 4'b0111);
  assign mov_ab = (op == 4'b0001);
  assign mov_ba = (op == 4'b0100);
  assign in_a   = (op == 4'b0010);
  assign in_b   = (op == 4'b0110);
  assign out_b  = (op == 4'b1001);
  assign out_i  = (op == 4'b1011);
  assign jmp    = (op == 4'b1111);
  assign jnc    = (op == 4'b1110);

  // Carry is cleared by every op that is not an ADD, NOP included.
  always_comb begin
    a_n   = a;
    b_n   = b;
    out_n = outp;
    c_n   = 1'b0;
    pc_n  = pc + 4'd1;
    unique case (1'b1)
      add_a: begin
        a_n = sum_a[3:0];
        c_n = sum_a[4];
      end
      add_b: begin
        b_n = sum_b[3:0];
        c_n = sum_b[4];
      end
      mov_ai: a_n   = im;
      mov_bi: b_n   = im;
      mov_ab: a_n   = b;
      mov_ba: b_n   = a;
      in_a:   a_n   = in_port;
      in_b:   b_n   = in_port;
      out_b:  out_n = b;
      out_i:  out_n = im;
      jmp:    pc_n  = im;
      jnc:    if (!c) pc_n = im;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= RESET_PC;
      a    <= 4'h0;
      b    <= 4'h0;
      c    <= 1'b0;
      outp <= OUT_RESET;
    end else if (en) begin
      pc   <= pc_n;
      a    <= a_n;
      b    <= b_n;
      c    <= c_n;
      outp <= out_n;
    end
  end

  assign adr      = pc;
  assign out_port = outp;
  assign carry    = c;

endmodule

// File: tb/tb_td4_core.sv
// Directed bench for td4_core with a behavioural 16x8 ROM.
// Expected values are hand-computed per program.
module tb_td4_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic [3:0] adr;
  logic [7:0] inst;
  logic [3:0] in_port = 4'h0;
  logic [3:0] out_port;
  logic       carry;

  logic [7:0] rom [16];
  int checks = 0;
  int passed = 0;

  assign inst = rom[adr];

  td4_core dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .adr      (adr),
    .inst     (inst),
    .in_port  (in_port),
    .out_port (out_port),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    fill(8'h80);
    #1 reset = 1'b1;
    #2;
    chk("rst_adr", {4'h0, adr}, 8'h00);
    chk("rst_out", {4'h0, out_port}, 8'h00);
    chk("rst_c", {7'h0, carry}, 8'h00);
    chk("rst_a", {4'h0, dut.a}, 8'h00);
    chk("rst_b", {4'h0, dut.b}, 8'h00);

    // MOV A,3; ADD A,5; MOV B,A; OUT B
    rom[0] = 8'h33; rom[1] = 8'h05;
    rom[2] = 8'h40; rom[3] = 8'h90;
    @(negedge clk);
    reset = 1'b0;
    step(1);
    chk("p2_a1", {4'h0, dut.a}, 8'h03);
    step(3);
    chk("p2_out", {4'h0, out_port}, 8'h08);
    chk("p2_b", {4'h0, dut.b}, 8'h08);
    chk("p2_c", {7'h0, carry}, 8'h00);
    chk("p2_adr", {4'h0, adr}, 8'h04);

    // MOV A,F; ADD A,1; JNC 7; OUT 1
    fill(8'h80);
    rom[0] = 8'h3F; rom[1] = 8'h01;
    rom[2] = 8'hE7; rom[3] = 8'hB1;
    do_reset();
    step(2);
    chk("p3_a", {4'h0, dut.a}, 8'h00);
    chk("p3_c1", {7'h0, carry}, 8'h01);
    step(1);
    chk("p3_jadr", {4'h0, adr}, 8'h03);
    chk("p3_c0", {7'h0, carry}, 8'h00);
    step(1);
    chk("p3_out", {4'h0, out_port}, 8'h01);
    chk("p3_adr", {4'h0, adr}, 8'h04);

    // OUT 3; ADD A,1; JNC 0; OUT F
    fill(8'h80);
    rom[0] = 8'hB3; rom[1] = 8'h01;
    rom[2] = 8'hE0; rom[3] = 8'hBF;
    do_reset();
    step(45);
    chk("p4_loop_adr", {4'h0, adr}, 8'h00);
    chk("p4_loop_a", {4'h0, dut.a}, 8'h0F);
    chk("p4_loop_out", {4'h0, out_port}, 8'h03);
    step(2);
    chk("p4_c16", {7'h0, carry}, 8'h01);
    step(1);
    chk("p4_exit_adr", {4'h0, adr}, 8'h03);
    chk("p4_exit_c", {7'h0, carry}, 8'h00);
    step(1);
    chk("p4_out", {4'h0, out_port}, 8'h0F);
    chk("p4_adr", {4'h0, adr}, 8'h04);

    // NOP sweep, wrap and enable hold
    fill(8'h80);
    do_reset();
    step(15);
    chk("p5_adrF", {4'h0, adr}, 8'h0F);
    step(1);
    chk("p5_wrap", {4'h0, adr}, 8'h00);
    step(1);
    chk("p5_adr1", {4'h0, adr}, 8'h01);
    fill(8'hB5);
    en = 1'b0;
    step(5);
    chk("p5_hold_adr", {4'h0, adr}, 8'h01);
    chk("p5_hold_out", {4'h0, out_port}, 8'h00);
    en = 1'b1;
    step(1);
    chk("p5_resume", {4'h0, out_port}, 8'h05);

    // IN A; OUT 0; MOV B,A; OUT B; ADD A,7 then mid-run reset
    fill(8'h80);
    rom[0] = 8'h20; rom[1] = 8'hB0;
    rom[2] = 8'h41; rom[3] = 8'h90;
    rom[4] = 8'h07;
    in_port = 4'hA;
    do_reset();
    step(1);
    chk("p6_in_a", {4'h0, dut.a}, 8'h0A);
    step(2);
    chk("p6_mov_b", {4'h0, dut.b}, 8'h0A);
    step(1);
    chk("p6_out_b", {4'h0, out_port}, 8'h0A);
    step(1);
    chk("p6_add_a", {4'h0, dut.a}, 8'h01);
    chk("p6_add_c", {7'h0, carry}, 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("p6_r_adr", {4'h0, adr}, 8'h00);
    chk("p6_r_out", {4'h0, out_port}, 8'h00);
    chk("p6_r_c", {7'h0, carry}, 8'h00);
    chk("p6_r_ab", {dut.a, dut.b}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    in_port = 4'h6;
    step(1);
    chk("p6_restart", {dut.a, adr}, 8'h61);

    // MOV B,C; ADD B,6; MOV A,B; IN B
    fill(8'h80);
    rom[0] = 8'h7C; rom[1] = 8'h56;
    rom[2] = 8'h10; rom[3] = 8'h66;
    rom[4] = 8'hF9;
    in_port = 4'h5;
    do_reset();
    step(2);
    chk("p7_add_b", {dut.a, dut.b}, 8'h02);
    chk("p7_c", {7'h0, carry}, 8'h01);
    step(1);
    chk("p7_mov_ab", {dut.a, dut.b}, 8'h22);
    chk("p7_c0", {7'h0, carry}, 8'h00);
    step(1);
    chk("p7_in_b", {dut.a, dut.b}, 8'h25);
    step(1);
    chk("p7_jmp", {4'h0, adr}, 8'h09);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
